i2s_audio_tx: RTL and testbench



---
 rtl/i2s_audio_tx_pkg.sv | 25 ++
 rtl/i2s_audio_tx_clk_div.sv | 66 ++++++
 rtl/i2s_audio_tx.sv | 91 +++++++++
 tb/tb_i2s_audio_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_audio_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_audio_tx_pkg
// Description : Shared constants for the I2S audio transmit path: default
//               sample width, LRCK polarity, silence value and the clock
//               divider defaults for a 100 MHz system clock.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_audio_tx_pkg;

    // Default sample width per channel
    localparam int          c_DEFAULT_DW        = 16;

    // Word-select level that marks the left channel
    localparam logic        c_LRCK_LEFT         = 1'b0;

    // Value loaded into both channels while muted
    localparam logic [15:0] c_SILENCE_SAMPLE    = 16'h0000;

    // 100 MHz clk -> 25 MHz MCLK, SCK = MCLK/8, LRCK = MCLK/256
    localparam int          c_DEFAULT_MCLK_HALF = 2;
    localparam int          c_DEFAULT_SCK_HALF  = 16;

endpackage : i2s_audio_tx_pkg
`default_nettype wire

// File: rtl/i2s_audio_tx_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : audio_clk_div
// Description : Free-running dividers for the DAC master clock and serial bit
//               clock. Both counters leave reset together so every SCK edge
//               lines up with an MCLK edge. sck_fall is high for the single
//               clk cycle whose closing edge takes SCK from 1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_clk_div
    import i2s_audio_tx_pkg::*;
#(
    parameter int MCLK_HALF = c_DEFAULT_MCLK_HALF,
    parameter int SCK_HALF  = c_DEFAULT_SCK_HALF
) (
    input  logic clk,
    input  logic rst_n,
    output logic audio_mclk,
    output logic audio_sck,
    output logic sck_fall
);

    // +1 keeps the counter at least one bit wide when a half-period is 1 clk
    localparam int                c_MW       = $clog2(MCLK_HALF + 1);
    localparam int                c_SW       = $clog2(SCK_HALF + 1);
    localparam logic [c_MW-1:0]   c_MCLK_TC  = c_MW'(MCLK_HALF - 1);
    localparam logic [c_SW-1:0]   c_SCK_TC   = c_SW'(SCK_HALF - 1);

    logic [c_MW-1:0] r_mclk_cnt;
    logic [c_SW-1:0] r_sck_cnt;
    logic            r_mclk;
    logic            r_sck;

    // MCLK half-period counter; toggle MCLK at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mclk_cnt <= '0;
            r_mclk     <= 1'b0;
        end else if (r_mclk_cnt == c_MCLK_TC) begin
            r_mclk_cnt <= '0;
            r_mclk     <= ~r_mclk;
        end else begin
            r_mclk_cnt <= r_mclk_cnt + c_MW'(1);
        end
    end

    // SCK half-period counter; toggle SCK at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (r_sck_cnt == c_SCK_TC) begin
            r_sck_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_sck_cnt <= r_sck_cnt + c_SW'(1);
        end
    end

    assign audio_mclk = r_mclk;
    assign audio_sck  = r_sck;
    // Upcoming edge will drop SCK; consumers act on that same edge
    assign sck_fall   = r_sck && (r_sck_cnt == c_SCK_TC);

endmodule : audio_clk_div
`default_nettype wire

// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_audio_tx
// Description : Standard I2S stereo transmitter. Latches a left/right pair at
//               the start of slot 1 and shifts it out MSB-first, one bit per
//               SCK falling edge, so slot 0 carries the previous right LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_audio_tx
    import i2s_audio_tx_pkg::*;
#(
    parameter int DW        = c_DEFAULT_DW,
    parameter int MCLK_HALF = c_DEFAULT_MCLK_HALF,
    parameter int SCK_HALF  = c_DEFAULT_SCK_HALF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] audio_left,
    input  logic [DW-1:0] audio_right,
    input  logic          mute,
    output logic          audio_mclk,
    output logic          audio_sck,
    output logic          audio_lrck,
    output logic          audio_sdin,
    output logic          sample_strobe
);

    localparam int              c_SLW         = $clog2(2 * DW);
    localparam logic [c_SLW-1:0] c_SLOT_LAST  = c_SLW'(2 * DW - 1);
    localparam logic [c_SLW-1:0] c_SLOT_LATCH = c_SLW'(1);
    localparam logic [c_SLW-1:0] c_SLOT_RIGHT = c_SLW'(DW);

    logic               w_sck_fall;
    logic [c_SLW-1:0]   w_slot_next;
    logic [c_SLW-1:0]   r_slot;
    logic [2*DW-1:0]    r_shift;
    logic               r_lrck;
    logic               r_strobe;

    audio_clk_div #(
        .MCLK_HALF (MCLK_HALF),
        .SCK_HALF  (SCK_HALF)
    ) u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .sck_fall   (w_sck_fall)
    );

    assign w_slot_next = (r_slot == c_SLOT_LAST) ? '0 : r_slot + c_SLW'(1);

    // Slot counter and word select, both advanced on SCK falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_lrck <= 1'b0;
        end else if (w_sck_fall) begin
            r_slot <= w_slot_next;
            r_lrck <= (w_slot_next >= c_SLOT_RIGHT) ? ~c_LRCK_LEFT : c_LRCK_LEFT;
        end
    end

    // Shift register: load the pair entering slot 1, otherwise shift left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_sck_fall) begin
            if (w_slot_next == c_SLOT_LATCH) begin
                r_shift <= mute ? {2{DW'(c_SILENCE_SAMPLE)}} : {audio_left, audio_right};
            end else begin
                r_shift <= {r_shift[2*DW-2:0], 1'b0};
            end
        end
    end

    // One-clk strobe marking the latch of a new pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_sck_fall && (w_slot_next == c_SLOT_LATCH);
        end
    end

    assign audio_lrck    = r_lrck;
    assign audio_sdin    = r_shift[2*DW-1];
    assign sample_strobe = r_strobe;

endmodule : i2s_audio_tx
`default_nettype wire

// File: tb/tb_i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_audio_tx
// Description : Self-checking bench for i2s_audio_tx. Two instances (default
//               and DW=8/MCLK_HALF=1/SCK_HALF=4) are compared every cycle
//               against a time-based reference model, plus directed frame
//               captures with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_tx;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a_l   = '0;
    logic [15:0] a_r   = '0;
    logic [7:0]  b_l   = '0;
    logic [7:0]  b_r   = '0;
    logic        mute  = 1'b0;

    logic a_mclk, a_sck, a_lrck, a_sdin, a_strobe;
    logic b_mclk, b_sck, b_lrck, b_sdin, b_strobe;

    int          checks   = 0;
    int          failures = 0;
    int          n        = 0;     // clk rising edges since reset release
    logic [63:0] wa       = '0;    // pair most recently latched, instance A
    logic [63:0] wb       = '0;    // pair most recently latched, instance B
    bit          run      = 1'b0;

    always #5 clk = ~clk;

    i2s_audio_tx dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .audio_left    (a_l),
        .audio_right   (a_r),
        .mute          (mute),
        .audio_mclk    (a_mclk),
        .audio_sck     (a_sck),
        .audio_lrck    (a_lrck),
        .audio_sdin    (a_sdin),
        .sample_strobe (a_strobe)
    );

    i2s_audio_tx #(
        .DW        (8),
        .MCLK_HALF (1),
        .SCK_HALF  (4)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .audio_left    (b_l),
        .audio_right   (b_r),
        .mute          (mute),
        .audio_mclk    (b_mclk),
        .audio_sck     (b_sck),
        .audio_lrck    (b_lrck),
        .audio_sdin    (b_sdin),
        .sample_strobe (b_strobe)
    );

    // Expected {mclk, sck, lrck, sdin, strobe} after n clk edges since release
    function automatic logic [4:0] model_out(input int dw, input int mh, input int sh,
                                             input int cyc, input logic [63:0] w);
        int         f;
        int         slot;
        logic [4:0] r;
        f    = cyc / (2 * sh);
        slot = f % (2 * dw);
        r[4] = ((cyc / mh) % 2) == 1;
        r[3] = ((cyc / sh) % 2) == 1;
        r[2] = slot >= dw;
        r[1] = (f == 0) ? 1'b0 : w[2 * dw - 1 - ((f - 1) % (2 * dw))];
        r[0] = (cyc > 0) && (cyc % (2 * sh) == 0) && (slot == 1);
        return r;
    endfunction

    // True when clk edge number m is the SCK fall that enters slot 1
    function automatic bit is_latch(input int m, input int dw, input int sh);
        return (m % (2 * sh) == 0) && ((m / (2 * sh)) % (2 * dw) == 1);
    endfunction

    function automatic logic [4:0] out_a();
        return {a_mclk, a_sck, a_lrck, a_sdin, a_strobe};
    endfunction

    function automatic logic [4:0] out_b();
        return {b_mclk, b_sck, b_lrck, b_sdin, b_strobe};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    // Reference timeline and latched words
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n  <= 0;
            wa <= '0;
            wb <= '0;
        end else begin
            n <= n + 1;
            if (is_latch(n + 1, 16, 16)) wa <= mute ? 64'h0 : {32'h0, a_l, a_r};
            if (is_latch(n + 1, 8, 4))   wb <= mute ? 64'h0 : {48'h0, b_l, b_r};
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (run) begin
            check("cycle_a", 64'(out_a()), 64'(model_out(16, 2, 16, n, wa)));
            check("cycle_b", 64'(out_b()), 64'(model_out(8, 1, 4, n, wb)));
        end
    end

    task automatic wait_strobe(input int which);
        int budget;
        bit seen;
        budget = 2100;
        seen   = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge clk);
            budget--;
            seen = (which == 0) ? a_strobe : b_strobe;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout dut=%0d actual=none required=strobe", which);
        end
    endtask

    task automatic wait_phase(input int modv, input int val);
        int budget;
        budget = 3000;
        while ((n % modv) != val && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if ((n % modv) != val) begin
            checks++;
            failures++;
            $display("FAIL phase_timeout actual=%0d required=%0d", n % modv, val);
        end
    endtask

    // Collect sdin and lrck on nbits SCK rising edges, MSB first
    task automatic capture(input int which, input int nbits,
                           output logic [63:0] data, output logic [63:0] lr);
        int   got;
        int   budget;
        logic prev;
        logic cur;
        data   = '0;
        lr     = '0;
        got    = 0;
        budget = 2200;
        prev   = (which == 0) ? a_sck : b_sck;
        while (got < nbits && budget > 0) begin
            @(negedge clk);
            budget--;
            cur = (which == 0) ? a_sck : b_sck;
            if (!prev && cur) begin
                data = {data[62:0], (which == 0) ? a_sdin : b_sdin};
                lr   = {lr[62:0],   (which == 0) ? a_lrck : b_lrck};
                got++;
            end
            prev = cur;
        end
        if (got < nbits) begin
            checks++;
            failures++;
            $display("FAIL capture_timeout dut=%0d actual=%0d required=%0d", which, got, nbits);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] lr;

        #1 rst_n = 1'b0;
        run = 1'b1;
        #2;
        check("reset_outputs_a", 64'(out_a()), 64'h0);
        check("reset_outputs_b", 64'(out_b()), 64'h0);

        a_l = 16'h8000; a_r = 16'h2FFF;
        b_l = 8'hA5;    b_r = 8'h3C;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // First latch 2*SCK_HALF clks after release
        wait_strobe(0);
        check("first_strobe_clk", 64'(n), 64'd32);
        capture(0, 32, d, lr);
        check("frame_a_data", d, 64'h8000_2FFF);
        check("frame_a_lrck", lr, 64'h0001_FFFE);

        // Small instance: A5 then 3C
        wait_strobe(1);
        capture(1, 16, d, lr);
        check("frame_b_data", d, 64'hA53C);
        check("frame_b_lrck", lr, 64'h01FE);

        // Input change at slot 5 and mute wiggle mid-frame are ignored
        a_l = 16'h1234; a_r = 16'h5678;
        wait_strobe(0);
        fork
            capture(0, 32, d, lr);
            begin
                repeat (128) @(negedge clk);
                a_l = 16'hABCD;
                repeat (200) @(negedge clk);
                mute = 1'b1;
                repeat (40) @(negedge clk);
                mute = 1'b0;
            end
        join
        check("midframe_change_cur", d, 64'h1234_5678);
        wait_strobe(0);
        capture(0, 32, d, lr);
        check("midframe_change_next", d, 64'hABCD_5678);

        // One-clk mute pulse on the latch edge silences the whole frame
        a_l = 16'h1357; a_r = 16'h9BDF;
        wait_phase(1024, 31);
        mute = 1'b1;
        wait_strobe(0);
        mute = 1'b0;
        capture(0, 32, d, lr);
        check("muted_frame", d, 64'h0);
        wait_strobe(0);
        capture(0, 32, d, lr);
        check("unmuted_frame", d, 64'h1357_9BDF);

        // Randomized traffic, checked by the cycle model
        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                a_l = 16'($urandom);
                a_r = 16'($urandom);
            end
            if ($urandom_range(0, 29) == 0) begin
                b_l = 8'($urandom);
                b_r = 8'($urandom);
            end
            if ($urandom_range(0, 99) == 0) mute = ~mute;
        end
        mute = 1'b0;

        // Reset at slot 20: outputs clear at once, sequencing restarts
        wait_phase(1024, 650);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs_a", 64'(out_a()), 64'h0);
        check("midreset_outputs_b", 64'(out_b()), 64'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_strobe(0);
        check("restart_strobe_clk", 64'(n), 64'd32);
        check("restart_lrck", 64'(a_lrck), 64'h0);
        repeat (200) @(negedge clk);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_i2s_audio_tx
`default_nettype wire
